sync_arb: RTL and testbench

Request synchronizer and round-robin scheduler for asynchronous event lines (console/UART/timer strobes) entering the KS10 clock domain. Each line passes through a two-flop synchronizer and a rising-edge detector, then is latched as pending. A round-robin arbiter serves pending events one at a time to a single consumer over a req/ack handshake. The block sits between raw asynchronous sources and the interrupt/event consumer logic.

---
 rtl/sync_arb_pkg.sv | 44 ++++
 rtl/sync_arb_sync.sv | 32 +++
 rtl/sync_arb.sv | 179 +++++++++++++++++
 tb/tb_sync_arb.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_arb_pkg.sv
// sync_arb_pkg: shared definitions for the sync_arb event scheduler.
// Holds the arbiter state encoding and the round-robin search helper used
// by the top level. Optional feature macro: SYNC_ARB_FILTER_EN (see sync_arb.sv).

package sync_arb_pkg;

   // Largest number of request lines the search helper is built for.
   localparam int MaxLines = 16;

   // Arbiter states: waiting for a pending event, or holding a grant.
   typedef enum logic [0:0] {
      sIDLE  = 1'b0,
      sGRANT = 1'b1
   } arbState_e;

   // Round-robin search: starting at ptr and walking upward modulo n, return
   // the index of the first set bit of pend. The wrap is modulo n (not modulo
   // a power of two) so non-power-of-two line counts rotate correctly. When
   // nothing is set the pointer itself is returned; callers only use the
   // result when pend is non-zero.
   function automatic logic [3:0] rr_pick(input logic [MaxLines-1:0] pend,
                                          input logic [3:0]          ptr,
                                          input int                  n);
      logic [3:0] pick;
      logic       found;
      logic [4:0] pos;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < MaxLines; k++) begin
         if (k < n) begin
            pos = {1'b0, ptr} + 5'(k);
            if (pos >= 5'(n)) begin
               pos = pos - 5'(n);
            end
            if (!found && pend[pos[3:0]]) begin
               pick  = pos[3:0];
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sync_arb_sync.sv
// SYNC: plain two-flop synchronizer for a bus of independent asynchronous
// lines. Each bit is treated separately; no bus coherency is implied.
// Both stages reset to INIT so a line already sitting at its INIT level
// does not look like a transition when reset is released.

module SYNC #(
   parameter int               WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // First stage may go metastable; the second stage gives it a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= INIT;
         sync_q <= INIT;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sync_arb.sv
// sync_arb: request synchronizer and round-robin scheduler for asynchronous
// event strobes entering the KS10 clock domain.
//
// Each line is synchronized, edge-detected and latched as pending. Pending
// events are handed out one at a time over an o_req/i_ack handshake, with a
// rotating pointer so every line gets a turn.
//
// Optional feature: define SYNC_ARB_FILTER_EN to insert a per-line stability
// filter between the synchronizer and the edge detector. A filtered level only
// follows the synchronized line after FILT_LEN consecutive differing cycles.
// Without the macro, FILT_LEN is only range-checked.

module sync_arb
   import sync_arb_pkg::*;
#(
   parameter int           N        = 4,
   parameter int           IDXW     = 2,
   parameter logic [N-1:0] INIT     = '0,
   parameter int           FILT_LEN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    i,
   output logic            o_req,
   output logic [IDXW-1:0] o_idx,
   input  logic            i_ack,
   output logic [N-1:0]    pend
);

   // Reject configurations the search helper or the index width cannot cover.
   if (N < 2 || N > MaxLines) begin : gBadLineCount
      $error("sync_arb: N must be in 2..16");
   end
   if ((1 << IDXW) < N) begin : gBadIndexWidth
      $error("sync_arb: IDXW too narrow for N");
   end
   if (FILT_LEN < 2 || FILT_LEN > 255) begin : gBadFilterLength
      $error("sync_arb: FILT_LEN must be in 2..255");
   end

   logic [N-1:0]    sLvl;
   logic [N-1:0]    lvl;
   logic [N-1:0]    h_q;
   logic [N-1:0]    rise;
   logic [N-1:0]    pend_q;
   logic [N-1:0]    pend_d;
   logic [N-1:0]    clrMask;
   logic            ackFire;
   arbState_e       state_q;
   logic            oReq_q;
   logic [IDXW-1:0] oIdx_q;
   logic [IDXW-1:0] ptr_q;
   logic [IDXW-1:0] ptr_d;
   logic [IDXW-1:0] pick;

   SYNC #(
      .WIDTH (N),
      .INIT  (INIT)
   ) uSync (
      .clk (clk),
      .rst (rst),
      .d_i (i),
      .q_o (sLvl)
   );

`ifdef SYNC_ARB_FILTER_EN
   localparam int FiltCntW = 8;

   logic [N-1:0]          filt_q;
   logic [N-1:0]          filt_d;
   logic [FiltCntW-1:0]   cnt_q [N];
   logic [FiltCntW-1:0]   cnt_d [N];

   // Count consecutive cycles the synchronized line disagrees with the filtered
   // level; flip the level on the FILT_LEN-th one, and restart on any agreement.
   always_comb begin
      filt_d = filt_q;
      for (int k = 0; k < N; k++) begin
         cnt_d[k] = '0;
         if (sLvl[k] != filt_q[k]) begin
            if (cnt_q[k] == FiltCntW'(FILT_LEN - 1)) begin
               filt_d[k] = sLvl[k];
            end else begin
               cnt_d[k] = cnt_q[k] + FiltCntW'(1);
            end
         end
      end
   end

   // Filter state; levels start at INIT so reset does not fabricate edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= INIT;
         for (int k = 0; k < N; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         filt_q <= filt_d;
         for (int k = 0; k < N; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sLvl;
`endif

   // Edge history: one cycle of delay on the (possibly filtered) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q <= INIT;
      end else begin
         h_q <= lvl;
      end
   end

   assign rise = lvl & ~h_q;

   // An acknowledged grant clears its own pending bit; a fresh edge on the same
   // cycle is ORed in afterwards so the new event is never dropped.
   assign ackFire = (state_q == sGRANT) && i_ack;
   assign clrMask = ackFire ? (N'(1) << oIdx_q) : '0;

   always_comb begin
      pend_d = (pend_q & ~clrMask) | rise;
   end

   // Pending register; repeated edges on an already-pending line coalesce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Pointer advance after an ack wraps at N so odd line counts rotate properly.
   assign ptr_d = (oIdx_q == IDXW'(N - 1)) ? '0 : oIdx_q + IDXW'(1);
   assign pick  = IDXW'(rr_pick(MaxLines'(pend_q), 4'(ptr_q), N));

   // Arbiter: pick the next pending line from IDLE, hold it in GRANT until the
   // consumer acknowledges. Returning through IDLE forces a low cycle on o_req.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= sIDLE;
         oReq_q  <= 1'b0;
         oIdx_q  <= '0;
         ptr_q   <= '0;
      end else begin
         case (state_q)
            sIDLE: begin
               if (pend_q != '0) begin
                  oIdx_q  <= pick;
                  oReq_q  <= 1'b1;
                  state_q <= sGRANT;
               end
            end
            sGRANT: begin
               if (i_ack) begin
                  oReq_q  <= 1'b0;
                  ptr_q   <= ptr_d;
                  state_q <= sIDLE;
               end
            end
            default: begin
               oReq_q  <= 1'b0;
               state_q <= sIDLE;
            end
         endcase
      end
   end

   assign o_req = oReq_q;
   assign o_idx = oIdx_q;
   assign pend  = pend_q;

endmodule

// File: tb/tb_sync_arb.sv
// tb_sync_arb: directed bench for sync_arb with a grant scoreboard.
// Stimulus pushes the expected grant order into a queue; a monitor pops and
// compares on every rising o_req. A second instance with INIT all ones and
// its lines tied high must never grant. With SYNC_ARB_FILTER_EN defined the
// filter-specific sequence runs instead of the unfiltered timing sequence.

module tb_sync_arb;

   logic       clk;
   logic       rst;
   logic [3:0] lines;
   logic       o_req;
   logic [1:0] o_idx;
   logic       i_ack;
   logic [3:0] pend;

   logic [3:0] allHigh = 4'hF;
   logic       oReq2;
   logic [1:0] oIdx2;
   logic [3:0] pend2;

   int vectors     = 0;
   int miscompares = 0;
   int grants2     = 0;

   int expQ[$];
   bit autoAck  = 1'b0;
   int ackDelay = 1;

   sync_arb #(.N(4), .IDXW(2), .INIT(4'b0000), .FILT_LEN(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .i     (lines),
      .o_req (o_req),
      .o_idx (o_idx),
      .i_ack (i_ack),
      .pend  (pend)
   );

   sync_arb #(.N(4), .IDXW(2), .INIT(4'b1111), .FILT_LEN(4)) dutInitHigh (
      .clk   (clk),
      .rst   (rst),
      .i     (allHigh),
      .o_req (oReq2),
      .o_idx (oIdx2),
      .i_ack (1'b1),
      .pend  (pend2)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive the request lines just after the next rising edge.
   task automatic applyStimulus(input logic [3:0] value);
      @(posedge clk);
      #1 lines = value;
   endtask

   task automatic waitIdle(input int maxCycles);
      int n = 0;
      while (!(o_req == 1'b0 && expQ.size() == 0 && pend == 4'b0000) && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain before timeout", 32'(n < maxCycles), 32'd1);
   endtask

   task automatic waitGrant(input int maxCycles);
      int n = 0;
      while (!o_req && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput("grant before timeout", 32'(o_req), 32'd1);
   endtask

   // Monitor: on each new grant pop the expected index; while held, o_idx must not move.
   initial begin
      bit prevReq = 1'b0;
      int heldIdx = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevReq = 1'b0;
         end else begin
            if (o_req && !prevReq) begin
               if (expQ.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected grant: got idx %0d, expected none", o_idx);
                  heldIdx = int'(o_idx);
               end else begin
                  heldIdx = expQ.pop_front();
                  checkOutput("grant index", 32'(o_idx), 32'(heldIdx));
               end
            end else if (o_req) begin
               checkOutput("grant index hold", 32'(o_idx), 32'(heldIdx));
            end
            prevReq = o_req;
         end
      end
   end

   // Consumer: when enabled, ack each grant ackDelay cycles after seeing it.
   initial begin
      forever begin
         @(negedge clk);
         if (autoAck && o_req && !i_ack) begin
            repeat (ackDelay) @(negedge clk);
            i_ack = 1'b1;
            @(negedge clk);
            i_ack = 1'b0;
         end
      end
   end

   // Count any grant from the INIT-high instance.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && oReq2) grants2++;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      lines = 4'b0000;
      i_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset o_req", 32'(o_req), 32'd0);
      checkOutput("reset o_idx", 32'(o_idx), 32'd0);
      checkOutput("reset pend", 32'(pend), 32'd0);
      checkOutput("reset o_req init-high", 32'(oReq2), 32'd0);
      rst = 1'b0;

`ifdef SYNC_ARB_FILTER_EN
      autoAck  = 1'b1;
      ackDelay = 1;
      // 3-cycle glitch must be swallowed by the filter
      applyStimulus(4'b0001);
      repeat (2) @(posedge clk);
      applyStimulus(4'b0000);
      repeat (15) @(posedge clk);
      #1;
      checkOutput("glitch pend", 32'(pend), 32'd0);
      checkOutput("glitch o_req", 32'(o_req), 32'd0);

      // 6-cycle pulse: grant arrives 4 cycles later than unfiltered
      expQ.push_back(0);
      applyStimulus(4'b0001);
      repeat (6) @(posedge clk);
      #1 lines = 4'b0000;
      checkOutput("filter o_req at E5", 32'(o_req), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("filter pend at E6", 32'(pend), 32'b0001);
      checkOutput("filter o_req at E6", 32'(o_req), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("filter o_req at E7", 32'(o_req), 32'd1);
      checkOutput("filter o_idx at E7", 32'(o_idx), 32'd0);
      waitIdle(100);
`else
      // Single event on line 2: pend at E2, o_req at E3
      autoAck  = 1'b1;
      ackDelay = 1;
      expQ.push_back(2);
      applyStimulus(4'b0100);
      repeat (3) @(posedge clk);
      #1 lines = 4'b0000;
      checkOutput("single pend at E2", 32'(pend), 32'b0100);
      checkOutput("single o_req at E2", 32'(o_req), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("single o_req at E3", 32'(o_req), 32'd1);
      checkOutput("single o_idx at E3", 32'(o_idx), 32'd2);
      waitIdle(50);
      checkOutput("single pend after ack", 32'(pend), 32'd0);

      // Pointer now 3: lines 0 and 3 give 3 then wrap to 0
      expQ.push_back(3);
      expQ.push_back(0);
      applyStimulus(4'b1001);
      repeat (3) @(posedge clk);
      #1 lines = 4'b0000;
      waitIdle(100);

      // Fresh reset, all four lines together: 0,1,2,3, then 0 and 3: 0,3
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      expQ.push_back(0);
      expQ.push_back(1);
      expQ.push_back(2);
      expQ.push_back(3);
      applyStimulus(4'b1111);
      waitIdle(200);
      applyStimulus(4'b0000);
      repeat (4) @(posedge clk);
      expQ.push_back(0);
      expQ.push_back(3);
      applyStimulus(4'b1001);
      waitIdle(100);
      applyStimulus(4'b0000);
      repeat (4) @(posedge clk);

      // Two edges on line 1 before the ack coalesce into one grant
      ackDelay = 12;
      expQ.push_back(1);
      applyStimulus(4'b0010);
      @(posedge clk);
      applyStimulus(4'b0000);
      @(posedge clk);
      applyStimulus(4'b0010);
      @(posedge clk);
      applyStimulus(4'b0000);
      waitIdle(100);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("coalesce pend", 32'(pend), 32'd0);

      // Edge on line 1 landing on the ack edge: set wins, second grant of 1
      autoAck = 1'b0;
      expQ.push_back(1);
      expQ.push_back(1);
      applyStimulus(4'b0010);
      repeat (2) @(posedge clk);
      applyStimulus(4'b0000);
      waitGrant(20);
      repeat (4) @(posedge clk);
      applyStimulus(4'b0010);
      @(posedge clk);
      @(posedge clk);
      #1 i_ack = 1'b1;
      @(posedge clk);
      #1 i_ack = 1'b0;
      checkOutput("set-wins pend", 32'(pend), 32'b0010);
      checkOutput("set-wins o_req after ack", 32'(o_req), 32'd0);
      applyStimulus(4'b0000);
      autoAck  = 1'b1;
      ackDelay = 0;
      waitIdle(50);

      // Ack held high in IDLE does nothing
      autoAck = 1'b0;
      @(posedge clk);
      #1 i_ack = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("idle ack o_req", 32'(o_req), 32'd0);
      checkOutput("idle ack pend", 32'(pend), 32'd0);
      i_ack = 1'b0;

      // 50-cycle ack delay: grant of 2 held, line 0 waits its turn
      autoAck  = 1'b1;
      ackDelay = 50;
      expQ.push_back(2);
      expQ.push_back(0);
      applyStimulus(4'b0100);
      repeat (2) @(posedge clk);
      applyStimulus(4'b0000);
      waitGrant(20);
      applyStimulus(4'b0001);
      repeat (2) @(posedge clk);
      applyStimulus(4'b0000);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("delayed ack o_req", 32'(o_req), 32'd1);
      checkOutput("delayed ack o_idx", 32'(o_idx), 32'd2);
      checkOutput("delayed ack pend", 32'(pend), 32'b0101);
      waitIdle(200);

      // Async reset between edges during a grant; line 0 held through reset
      autoAck = 1'b0;
      expQ.push_back(1);
      applyStimulus(4'b1010);
      waitGrant(20);
      checkOutput("pre-reset pend", 32'(pend), 32'b1010);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid-grant reset o_req", 32'(o_req), 32'd0);
      checkOutput("mid-grant reset o_idx", 32'(o_idx), 32'd0);
      checkOutput("mid-grant reset pend", 32'(pend), 32'd0);
      lines = 4'b0001;
      repeat (3) @(posedge clk);
      expQ.push_back(0);
      autoAck  = 1'b1;
      ackDelay = 1;
      #1 rst = 1'b0;
      waitIdle(50);
      applyStimulus(4'b0000);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("post-reset pend", 32'(pend), 32'd0);
`endif

      checkOutput("init-high grants", 32'(grants2), 32'd0);
      checkOutput("init-high pend", 32'(pend2), 32'd0);
      checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
